// File: rtl/lmg_move_unpacker_pkg.sv
// Shared constants, slot extraction helper and FSM state encoding for the LMG move unpacker.
package lmg_move_unpacker_pkg;

    localparam int MOVE_W     = 18;
    localparam int SLOT_W     = 19;
    localparam int LMG_SLOTS  = 8;
    localparam int LMG_WORD_W = 152;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_DONE = 3'd1;
    localparam logic [2:0] ST_REQ       = 3'd2;
    localparam logic [2:0] ST_CAPTURE   = 3'd3;
    localparam logic [2:0] ST_EMIT      = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    // Slot k occupies bits [19k+18:19k]; bit 19k+18 is its invalid flag.
    function automatic logic [SLOT_W-1:0] get_slot(input logic [LMG_WORD_W-1:0] word,
                                                   input logic [2:0]            k);
        return word[int'(k)*SLOT_W +: SLOT_W];
    endfunction

endpackage

// File: rtl/lmg_move_unpacker_slot_pick.sv
// Lowest-set-bit encoder over the pending-slot mask of one LMG word.
module lmg_move_unpacker_slot_pick
    import lmg_move_unpacker_pkg::*;
(
    input  logic [LMG_SLOTS-1:0] pending_mask,
    output logic [2:0]           slot_idx,
    output logic                 any_pending
);

    // Scan from the top so the lowest set bit is the last one to win.
    always_comb begin
        slot_idx    = 3'd0;
        any_pending = |pending_mask;
        for (int k = LMG_SLOTS - 1; k >= 0; k--) begin
            slot_idx = pending_mask[k] ? 3'(k) : slot_idx;
        end
    end

endmodule

// File: rtl/lmg_move_unpacker.sv
// Pops LMG FIFO words and streams their valid moves, one per cycle, with a running index
// and end-of-list / saturation reporting.
module lmg_move_unpacker #(
    parameter int MOVE_W  = 18,
    parameter int SLOTS   = 8,
    parameter int COUNT_W = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        lmg_done,
    input  logic                        fifo_empty,
    output logic                        fifo_rden,
    input  logic [SLOTS*(MOVE_W+1)-1:0] fifo_data,
    output logic                        move_valid,
    input  logic                        move_ready,
    output logic [MOVE_W-1:0]           move_data,
    output logic [COUNT_W-1:0]          move_index,
    output logic                        list_done,
    output logic [COUNT_W-1:0]          move_count,
    output logic                        overflow
);
    import lmg_move_unpacker_pkg::*;

    localparam int                 WORD_W_L  = SLOTS * (MOVE_W + 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    logic [2:0]          state_q, state_d;
    logic [WORD_W_L-1:0] word_q, word_d;
    logic [SLOTS-1:0]    mask_q, mask_d;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic                overflow_q, overflow_d;

    logic [SLOTS-1:0]    cap_mask_s;
    logic [SLOTS-1:0]    pick_onehot_s;
    logic [2:0]          pick_idx_s;
    logic                any_pending_s;
    logic [SLOT_W-1:0]   cur_slot_s;
    logic                saturated_s;
    logic                move_valid_s;
    logic                handshake_s;

    lmg_move_unpacker_slot_pick u_slot_pick (
        .pending_mask (mask_q),
        .slot_idx     (pick_idx_s),
        .any_pending  (any_pending_s)
    );

    assign cur_slot_s    = get_slot(word_q, pick_idx_s);
    assign pick_onehot_s = {{(SLOTS-1){1'b0}}, 1'b1} << pick_idx_s;
    assign saturated_s   = (count_q == COUNT_MAX);
    // A saturated count suppresses presentation; the slot is dropped in EMIT instead.
    assign move_valid_s  = (state_q == ST_EMIT) && any_pending_s && !saturated_s
                           && !cur_slot_s[MOVE_W];
    assign handshake_s   = move_valid_s && move_ready;

    assign fifo_rden  = (state_q == ST_REQ) && !fifo_empty;
    assign move_valid = move_valid_s;
    assign move_data  = move_valid_s ? cur_slot_s[MOVE_W-1:0] : {MOVE_W{1'b0}};
    assign move_index = move_valid_s ? count_q : {COUNT_W{1'b0}};
    assign list_done  = (state_q == ST_DONE);
    assign move_count = count_q;
    assign overflow   = overflow_q;

    // Pending mask of the word currently on fifo_data: one bit per valid slot.
    always_comb begin
        cap_mask_s = {SLOTS{1'b0}};
        for (int k = 0; k < SLOTS; k++) begin
            cap_mask_s[k] = ~fifo_data[k*(MOVE_W+1) + MOVE_W];
        end
    end

    // Next-state and datapath update for the unpacking FSM.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        mask_d     = mask_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (start) begin
            state_d    = ST_WAIT_DONE;
            word_d     = {WORD_W_L{1'b0}};
            mask_d     = {SLOTS{1'b0}};
            count_d    = {COUNT_W{1'b0}};
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_WAIT_DONE: begin
                    state_d = lmg_done ? ST_REQ : ST_WAIT_DONE;
                end
                ST_REQ: begin
                    state_d = fifo_empty ? ST_DONE : ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    word_d  = fifo_data;
                    mask_d  = cap_mask_s;
                    state_d = (cap_mask_s == {SLOTS{1'b0}}) ? ST_DONE : ST_EMIT;
                end
                ST_EMIT: begin
                    if (!any_pending_s) begin
                        state_d = ST_REQ;
                    end else if (saturated_s) begin
                        mask_d     = {SLOTS{1'b0}};
                        overflow_d = 1'b1;
                        state_d    = ST_REQ;
                    end else if (handshake_s) begin
                        mask_d  = mask_q & ~pick_onehot_s;
                        count_d = count_q + COUNT_ONE;
                        state_d = (mask_d == {SLOTS{1'b0}}) ? ST_REQ : ST_EMIT;
                    end else begin
                        state_d = ST_EMIT;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers; reset takes priority over everything, including start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            word_q     <= {WORD_W_L{1'b0}};
            mask_q     <= {SLOTS{1'b0}};
            count_q    <= {COUNT_W{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            mask_q     <= mask_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_lmg_move_unpacker.sv
// Directed self-checking bench for lmg_move_unpacker with a queue-based LMG FIFO model.
module tb_lmg_move_unpacker;

    localparam int MOVE_W  = 18;
    localparam int SLOTS   = 8;
    localparam int COUNT_W = 8;
    localparam int WORD_W  = SLOTS * (MOVE_W + 1);

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic                lmg_done;
    logic                fifo_empty;
    logic                fifo_rden;
    logic [WORD_W-1:0]   fifo_data;
    logic                move_valid;
    logic                move_ready;
    logic [MOVE_W-1:0]   move_data;
    logic [COUNT_W-1:0]  move_index;
    logic                list_done;
    logic [COUNT_W-1:0]  move_count;
    logic                overflow;

    int                  n_checks = 0;
    int                  n_fail   = 0;
    logic [WORD_W-1:0]   fifo_q[$];
    logic                pop_pend;

    always #5 clk = ~clk;

    lmg_move_unpacker #(
        .MOVE_W  (MOVE_W),
        .SLOTS   (SLOTS),
        .COUNT_W (COUNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .lmg_done   (lmg_done),
        .fifo_empty (fifo_empty),
        .fifo_rden  (fifo_rden),
        .fifo_data  (fifo_data),
        .move_valid (move_valid),
        .move_ready (move_ready),
        .move_data  (move_data),
        .move_index (move_index),
        .list_done  (list_done),
        .move_count (move_count),
        .overflow   (overflow)
    );

    function automatic logic [WORD_W-1:0] make_word(input logic [7:0] valid, input logic [17:0] base);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int k = 0; k < SLOTS; k++) begin
            w[k*19 +: 19] = {~valid[k], base + 18'(k)};
        end
        return w;
    endfunction

    // {rden, valid, data, index, list_done, count, overflow}
    function automatic logic [37:0] pack(input logic r, input logic v, input logic [17:0] d,
                                         input logic [7:0] i, input logic ld,
                                         input logic [7:0] c, input logic o);
        return {r, v, d, i, ld, c, o};
    endfunction

    function automatic logic [37:0] observe();
        return pack(fifo_rden, move_valid, move_data, move_index, list_done, move_count, overflow);
    endfunction

    // Advance one cycle; a pop seen in the previous cycle delivers its word now.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        if (pop_pend) begin
            if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
            fifo_empty = (fifo_q.size() == 0);
            pop_pend   = 1'b0;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        pop_pend = fifo_rden;
    endtask

    task automatic apply_reset();
        reset = 1'b1; start = 1'b0; lmg_done = 1'b0; move_ready = 1'b0; pop_pend = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic load_fifo(input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1, input int n);
        fifo_q.delete();
        if (n > 0) fifo_q.push_back(w0);
        if (n > 1) fifo_q.push_back(w1);
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic test_reset();
        apply_reset();
        settle();
        n_checks++;
        if (observe() !== 38'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", observe(), 38'h0);
        end
    endtask

    task automatic test_basic();
        logic [37:0] exp;
        apply_reset();
        load_fifo(make_word(8'h89, 18'h01000), make_word(8'h00, 18'h03000), 2);
        move_ready = 1'b1;
        lmg_done   = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            next_cycle();
            start = (cyc == 0);
            settle();
            case (cyc)
                2:          exp = pack(1'b1, 1'b0, 18'h0, 8'd0, 1'b0, 8'd0, 1'b0);
                4:          exp = pack(1'b0, 1'b1, 18'h01000, 8'd0, 1'b0, 8'd0, 1'b0);
                5:          exp = pack(1'b0, 1'b1, 18'h01003, 8'd1, 1'b0, 8'd1, 1'b0);
                6:          exp = pack(1'b0, 1'b1, 18'h01007, 8'd2, 1'b0, 8'd2, 1'b0);
                7:          exp = pack(1'b1, 1'b0, 18'h0, 8'd0, 1'b0, 8'd3, 1'b0);
                8:          exp = pack(1'b0, 1'b0, 18'h0, 8'd0, 1'b0, 8'd3, 1'b0);
                9, 10, 11:  exp = pack(1'b0, 1'b0, 18'h0, 8'd0, 1'b1, 8'd3, 1'b0);
                default:    exp = 38'h0;
            endcase
            n_checks++;
            if (observe() !== exp) begin
                n_fail++;
                $display("FAIL basic cyc%0d: got %h expected %h", cyc, observe(), exp);
            end
        end
    endtask

    task automatic test_stall();
        logic [37:0] exp;
        apply_reset();
        load_fifo(make_word(8'h89, 18'h01000), make_word(8'h00, 18'h03000), 2);
        lmg_done = 1'b1;
        for (int cyc = 0; cyc < 13; cyc++) begin
            next_cycle();
            start      = (cyc == 0);
            move_ready = !(cyc == 5 || cyc == 6);
            settle();
            case (cyc)
                2:          exp = pack(1'b1, 1'b0, 18'h0, 8'd0, 1'b0, 8'd0, 1'b0);
                4:          exp = pack(1'b0, 1'b1, 18'h01000, 8'd0, 1'b0, 8'd0, 1'b0);
                5, 6, 7:    exp = pack(1'b0, 1'b1, 18'h01003, 8'd1, 1'b0, 8'd1, 1'b0);
                8:          exp = pack(1'b0, 1'b1, 18'h01007, 8'd2, 1'b0, 8'd2, 1'b0);
                9:          exp = pack(1'b1, 1'b0, 18'h0, 8'd0, 1'b0, 8'd3, 1'b0);
                10:         exp = pack(1'b0, 1'b0, 18'h0, 8'd0, 1'b0, 8'd3, 1'b0);
                11, 12:     exp = pack(1'b0, 1'b0, 18'h0, 8'd0, 1'b1, 8'd3, 1'b0);
                default:    exp = 38'h0;
            endcase
            n_checks++;
            if (observe() !== exp) begin
                n_fail++;
                $display("FAIL stall cyc%0d: got %h expected %h", cyc, observe(), exp);
            end
        end
    endtask

    task automatic test_empty();
        logic [37:0] exp;
        apply_reset();
        load_fifo('0, '0, 0);
        move_ready = 1'b1;
        lmg_done   = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            next_cycle();
            start = (cyc == 0);
            settle();
            exp = (cyc >= 3) ? pack(1'b0, 1'b0, 18'h0, 8'd0, 1'b1, 8'd0, 1'b0) : 38'h0;
            n_checks++;
            if (observe() !== exp) begin
                n_fail++;
                $display("FAIL empty cyc%0d: got %h expected %h", cyc, observe(), exp);
            end
        end
    endtask

    task automatic test_overflow();
        int   n_hs;
        logic prev_rden;
        logic seen_done;
        apply_reset();
        fifo_q.delete();
        for (int w = 0; w < 40; w++) fifo_q.push_back(make_word(8'hFF, 18'(w * 8)));
        fifo_empty = 1'b0;
        move_ready = 1'b1;
        lmg_done   = 1'b1;
        n_hs       = 0;
        prev_rden  = 1'b0;
        seen_done  = 1'b0;
        for (int cyc = 0; cyc < 2000 && !seen_done; cyc++) begin
            next_cycle();
            start = (cyc == 0);
            settle();
            if (fifo_rden && (fifo_empty || prev_rden)) begin
                n_fail++;
                $display("FAIL rden_protocol cyc%0d: rden=1 empty=%0b prev_rden=%0b", cyc, fifo_empty, prev_rden);
            end
            prev_rden = fifo_rden;
            if (move_valid && move_ready) begin
                n_checks++;
                if (move_data !== 18'(n_hs) || move_index !== 8'(n_hs)) begin
                    n_fail++;
                    $display("FAIL ovf_move%0d: got data %h index %0d expected data %h index %0d",
                             n_hs, move_data, move_index, 18'(n_hs), 8'(n_hs));
                end
                n_hs++;
            end
            seen_done = list_done;
        end
        n_checks++;
        if (!seen_done) begin
            n_fail++;
            $display("FAIL ovf_timeout: list_done never rose within 2000 cycles");
        end
        n_checks++;
        if (move_count !== 8'd255 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_final: got count %0d overflow %0b expected count 255 overflow 1", move_count, overflow);
        end
        n_checks++;
        if (n_hs != 255 || fifo_q.size() != 0) begin
            n_fail++;
            $display("FAIL ovf_moves: got %0d handshakes %0d words left expected 255 handshakes 0 left", n_hs, fifo_q.size());
        end
    endtask

    task automatic test_reset_priority();
        logic [37:0] exp;
        logic        chk;
        apply_reset();
        load_fifo(make_word(8'h89, 18'h01000), make_word(8'h06, 18'h02000), 2);
        for (int cyc = 0; cyc < 19; cyc++) begin
            next_cycle();
            case (cyc)
                0:       begin start = 1'b1; lmg_done = 1'b1; move_ready = 1'b0; end
                5:       begin start = 1'b0; reset = 1'b1; lmg_done = 1'b0; end
                6:       begin reset = 1'b1; start = 1'b1; end
                7:       begin reset = 1'b0; start = 1'b0; end
                8:       begin lmg_done = 1'b1; end
                12:      begin lmg_done = 1'b0; start = 1'b1; end
                14:      begin lmg_done = 1'b1; move_ready = 1'b1; end
                default: begin start = 1'b0; end
            endcase
            settle();
            chk = 1'b1;
            case (cyc)
                4:                       exp = pack(1'b0, 1'b1, 18'h01000, 8'd0, 1'b0, 8'd0, 1'b0);
                6, 7, 8, 9, 10, 11, 13:  exp = 38'h0;
                14, 16:                  exp = 38'h0;
                15:                      exp = pack(1'b1, 1'b0, 18'h0, 8'd0, 1'b0, 8'd0, 1'b0);
                17:                      exp = pack(1'b0, 1'b1, 18'h02001, 8'd0, 1'b0, 8'd0, 1'b0);
                18:                      exp = pack(1'b0, 1'b1, 18'h02002, 8'd1, 1'b0, 8'd1, 1'b0);
                default: begin           exp = 38'h0; chk = 1'b0; end
            endcase
            if (chk) begin
                n_checks++;
                if (observe() !== exp) begin
                    n_fail++;
                    $display("FAIL reset_prio cyc%0d: got %h expected %h", cyc, observe(), exp);
                end
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        lmg_done   = 1'b0;
        move_ready = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        pop_pend   = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_empty();
        test_overflow();
        test_reset_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
